// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration-load stage.
package cfg_pkg;

    // Frame width of a connection block: 6 dots x 3 bits.
    localparam int CB_FRAME_W = 18;

    // Widest tile chain the one-hot helper can address.
    localparam int MAX_TILES = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_e;

    // One-hot write-enable vector for tile idx; callers truncate to their tile count.
    function automatic logic [MAX_TILES-1:0] onehot(input int unsigned idx);
        return {{(MAX_TILES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/cfg_loader.sv
// Serial configuration loader: assembles even-parity-checked frames from a
// valid/ready bitstream and strobes them into tiles 0..NUM_TILES-1 in order.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start_i
// SHIFT  | accepting the FRAME_W data bits of the current tile, MSB first
// PARITY | accepting the even-parity bit of the current frame
// WRITE  | one-cycle wr_en strobe for the current tile, bits_o = frame
// DONE   | every tile written; done_o held until the next start_i
// ERROR  | parity mismatch; err_o held until the next start_i
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int FRAME_W   = CB_FRAME_W,
    parameter int NUM_TILES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 cfg_data_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    output logic [FRAME_W-1:0]   bits_o,
    output logic [NUM_TILES-1:0] wr_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int CNT_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(NUM_TILES - 1);

    state_e                state_q, state_d;
    logic [FRAME_W-1:0]    sr_q, sr_d;
    logic                  par_q, par_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TILE_W-1:0]     tile_q, tile_d;
    logic [NUM_TILES-1:0]  wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready;
    logic                  xfer;

    // Ready/busy decode straight from the state register.
    always_comb begin
        ready  = (state_q == SHIFT) || (state_q == PARITY);
        busy_o = (state_q == SHIFT) || (state_q == PARITY) || (state_q == WRITE);
        xfer   = ready && cfg_valid_i;
    end

    assign cfg_ready_o = ready;
    assign bits_o      = sr_q;
    assign wr_en_o     = wr_en_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

    // Next-state, datapath and strobe computation; everything holds by default.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        tile_d  = tile_q;
        wr_en_d = '0;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d = SHIFT;
                    tile_d  = '0;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    sr_d  = {sr_q[FRAME_W-2:0], cfg_data_i};
                    par_d = par_q ^ cfg_data_i;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (xfer) begin
                    // Strobe is registered here so it is high for the whole WRITE cycle.
                    if ((par_q ^ cfg_data_i) == 1'b0) begin
                        state_d = WRITE;
                        wr_en_d = NUM_TILES'(onehot(32'(tile_q)));
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (tile_q == TILE_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SHIFT;
                    tile_d  = tile_q + TILE_W'(1);
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            tile_q  <= '0;
            wr_en_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            tile_q  <= tile_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed, table-driven bench for cfg_loader with two 18-bit tiles.
module tb_cfg_loader;
    import cfg_pkg::*;

    localparam int FW = 18;
    localparam int NT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          cfg_data_i = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [FW-1:0] bits_o;
    logic [NT-1:0] wr_en_o;
    logic          busy_o, done_o, err_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    typedef struct {
        logic [NT-1:0] we;
        logic [FW-1:0] bits;
        int            rel;
    } pulse_t;
    pulse_t pulses[$];

    typedef struct {
        logic [FW-1:0] frame0;
        logic          par0;
        logic [FW-1:0] frame1;
        logic          par1;
        bit            gap;
        int            start_at;
        int            exp_pulses;
        bit            exp_err;
        bit            exp_done;
        int            exp_t0;
        int            exp_t1;
        int            exp_tend;
    } vec_t;
    vec_t vecs[7];

    cfg_loader #(.FRAME_W(FW), .NUM_TILES(NT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .cfg_data_i (cfg_data_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .bits_o     (bits_o),
        .wr_en_o    (wr_en_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Strobe recorder and always-on invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en_o != '0) pulses.push_back('{wr_en_o, bits_o, cyc - c0 + 1});
            checks++;
            if (!$onehot0(wr_en_o)) begin
                errors++;
                $display("FAIL onehot0 wr_en actual=%b required=onehot0", wr_en_o);
            end
            checks++;
            if ((wr_en_o != '0) != (dut.state_q == WRITE)) begin
                errors++;
                $display("FAIL wr_en_only_in_write wr_en=%b state=%0d", wr_en_o, dut.state_q);
            end
            checks++;
            if ((dut.state_q == WRITE || dut.state_q == DONE || dut.state_q == ERROR) && cfg_ready_o) begin
                errors++;
                $display("FAIL ready_low state=%0d actual=1 required=0", dut.state_q);
            end
        end
    end

    // Present one bit and hold it until it is accepted.
    task automatic send_bit(input logic b, input bit gap, input bit pulse_start);
        bit ok;
        if (gap) begin
            cfg_valid_i = 1'b0;
            @(negedge clk);
        end
        cfg_valid_i = 1'b1;
        cfg_data_i  = b;
        if (pulse_start) start_i = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (cfg_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'(cfg_ready_o), 32'd1);
        @(negedge clk);
        start_i     = 1'b0;
        cfg_valid_i = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        c0 = cyc;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        logic [FW:0] w [2];
        int nb;
        int rel_end;
        int n;
        v = vecs[idx];
        w[0] = {v.frame0, v.par0};
        w[1] = {v.frame1, v.par1};
        pulses.delete();
        do_start();
        check($sformatf("v%0d_start_state", idx), 32'({busy_o, done_o, err_o}), 32'b100);
        nb = 0;
        for (int t = 0; t < NT; t++) begin
            if (err_o) break;
            for (int b = FW; b >= 0; b--) begin
                send_bit(w[t][b], v.gap && (nb > 0), nb == v.start_at);
                nb++;
            end
        end
        rel_end = -1;
        for (int k = 0; k < 300; k++) begin
            if (done_o || err_o) begin
                rel_end = cyc - c0 + 1;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_end_cycle", idx), 32'(rel_end), 32'(v.exp_tend));
        check($sformatf("v%0d_done", idx), 32'(done_o), 32'(v.exp_done));
        check($sformatf("v%0d_err", idx), 32'(err_o), 32'(v.exp_err));
        check($sformatf("v%0d_ready", idx), 32'(cfg_ready_o), 32'd0);
        check($sformatf("v%0d_npulses", idx), 32'(pulses.size()), 32'(v.exp_pulses));
        for (int i = 0; i < pulses.size() && i < NT; i++) begin
            check($sformatf("v%0d_p%0d_we", idx, i), 32'(pulses[i].we), 32'(1 << i));
            check($sformatf("v%0d_p%0d_bits", idx, i), 32'(pulses[i].bits),
                  32'((i == 0) ? v.frame0 : v.frame1));
            check($sformatf("v%0d_p%0d_cycle", idx, i), 32'(pulses[i].rel),
                  32'((i == 0) ? v.exp_t0 : v.exp_t1));
        end
        n = pulses.size();
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_hold_pulses", idx), 32'(pulses.size()), 32'(n));
        check($sformatf("v%0d_hold_flags", idx), 32'({done_o, err_o}), 32'({v.exp_done, v.exp_err}));
    endtask

    initial begin
        logic [FW:0] w0;
        //            frame0    p0    frame1    p1    gap  st  np err done t0  t1  tend
        vecs[0] = '{18'h2A5A5, 1'b1, 18'h00000, 1'b0, 1'b0, -1, 2, 1'b0, 1'b1, 20, 40, 41};
        vecs[1] = '{18'h2A5A5, 1'b1, 18'h00000, 1'b0, 1'b1, -1, 2, 1'b0, 1'b1, 38, 76, 77};
        vecs[2] = '{18'h2A5A5, 1'b0, 18'h00000, 1'b0, 1'b0, -1, 0, 1'b1, 1'b0,  0,  0, 20};
        vecs[3] = '{18'h2A5A5, 1'b1, 18'h00000, 1'b0, 1'b0, -1, 2, 1'b0, 1'b1, 20, 40, 41};
        vecs[4] = '{18'h2A5A5, 1'b1, 18'h00000, 1'b0, 1'b0,  5, 2, 1'b0, 1'b1, 20, 40, 41};
        vecs[5] = '{18'h3FFFF, 1'b0, 18'h00001, 1'b0, 1'b0, -1, 1, 1'b1, 1'b0, 20,  0, 40};
        vecs[6] = '{18'h3FFFF, 1'b0, 18'h00001, 1'b1, 1'b0, -1, 2, 1'b0, 1'b1, 20, 40, 41};

        #2;
        check("rst_outputs", 32'({cfg_ready_o, busy_o, done_o, err_o, wr_en_o}), 32'd0);
        check("rst_bits", 32'(bits_o), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        #20 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready", 32'({cfg_ready_o, busy_o}), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Reset after 10 bits of tile 1.
        pulses.delete();
        do_start();
        w0 = {18'h2A5A5, 1'b1};
        for (int b = FW; b >= 0; b--) send_bit(w0[b], 1'b0, 1'b0);
        for (int b = 0; b < 10; b++) send_bit(1'(b & 1), 1'b0, 1'b0);
        check("mid_busy_before_rst", 32'(busy_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs", 32'({cfg_ready_o, busy_o, done_o, err_o, wr_en_o}), 32'd0);
        check("midrst_bits", 32'(bits_o), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        check("midrst_tile0_written", 32'(pulses.size()), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
